// File: rtl/alu_seq.sv
// Sequencer around an external combinational ALU: reads operands from a small
// register file, presents them to the ALU, and writes the result back.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs1,
  input  logic [1:0]       cmd_rs2,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only in IDLE, so at most one
  // command is in flight and throughput is one command per three cycles.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] regs [NREG];
  logic [1:0]       rd_q;
  logic             accept;

  assign accept    = cmd_valid & cmd_ready;
  assign rd_data   = regs[rd_addr];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = EXEC;
      end
      EXEC: state_nx = WB;
      WB: begin
        res_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are read from pre-edge register contents, so a same-edge load
  // is not forwarded. The writeback is ordered after the load port so it
  // wins when both target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rd_q     <= '0;
      res_data <= '0;
      res_cout <= 1'b0;
      res_zero <= 1'b0;
    end else begin
      if (ld_en) regs[ld_addr] <= ld_data;
      if (accept) begin
        alu_a  <= regs[cmd_rs1];
        alu_b  <= cmd_imm_en ? cmd_imm : regs[cmd_rs2];
        alu_op <= cmd_op;
        rd_q   <= cmd_rd;
      end
      if (state == EXEC) begin
        regs[rd_q] <= alu_y;
        res_data   <= alu_y;
        res_cout   <= alu_cout;
        res_zero   <= (alu_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: table-driven commands, hand-written corner
// sequences, and a result scoreboard fed at accept and drained on res_valid.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [1:0]   cmd_rd = '0;
  logic [1:0]   cmd_rs1 = '0;
  logic [1:0]   cmd_rs2 = '0;
  logic         cmd_imm_en = 1'b0;
  logic [W-1:0] cmd_imm = '0;
  logic         ld_en = 1'b0;
  logic [1:0]   ld_addr = '0;
  logic [W-1:0] ld_data = '0;
  logic [1:0]   rd_addr = '0;
  logic [W-1:0] rd_data;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_y = '0;
  logic         alu_cout = 1'b0;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_cout;
  logic         res_zero;
  logic [1:0]   dbg_state;

  alu_seq #(.WIDTH(W), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_data(res_data), .res_cout(res_cout),
    .res_zero(res_zero), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           failures = 0;
  logic [W+1:0] exp_q[$];   // {cout, zero, data}
  logic [W+1:0] exp_e;
  logic [W-1:0] model [4];
  int           pulses = 0;
  time          last_pulse = 0;
  time          pulse_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      pulses++;
      pulse_gap  = $time - last_pulse;
      last_pulse = $time;
      if (exp_q.size() == 0) begin
        chk("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("res_data", {16'd0, res_data}, {16'd0, exp_e[W-1:0]});
        chk("res_zero", {31'd0, res_zero}, {31'd0, exp_e[W]});
        chk("res_cout", {31'd0, res_cout}, {31'd0, exp_e[W+1]});
      end
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic load(input logic [1:0] a, input logic [W-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); @(negedge clk);
    ld_en = 1'b0;
    model[a] = d;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic [1:0] rd, input logic imm_en, input logic [W-1:0] imm,
                       input logic [W-1:0] y, input logic cout, input logic zero);
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    ea = model[rs1];
    eb = imm_en ? imm : model[rs2];
    cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    cmd_imm_en = imm_en; cmd_imm = imm; alu_y = y; alu_cout = cout;
    exp_q.push_back({cout, zero, y});
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; ld_en = 1'b0;
    chk("cmd_ready_exec", {31'd0, cmd_ready}, 32'd0);
    chk("state_exec", {30'd0, dbg_state}, 32'd1);
    chk("alu_a", {16'd0, alu_a}, {16'd0, ea});
    chk("alu_b", {16'd0, alu_b}, {16'd0, eb});
    chk("alu_op", {29'd0, alu_op}, {29'd0, op});
  endtask

  task automatic finish_cmd(input logic [1:0] rd, input logic [W-1:0] y);
    @(posedge clk); @(negedge clk);
    ld_en = 1'b0;
    model[rd] = y;
    chk("cmd_ready_wb", {31'd0, cmd_ready}, 32'd0);
    rd_addr = rd; #1;
    chk("reg_writeback", {16'd0, rd_data}, {16'd0, y});
    @(posedge clk); @(negedge clk);
    chk("res_valid_after_wb", {31'd0, res_valid}, 32'd0);
    chk("cmd_ready_after_wb", {31'd0, cmd_ready}, 32'd1);
    chk("res_data_hold", {16'd0, res_data}, {16'd0, y});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_res_cout", {31'd0, res_cout}, 32'd0);
    chk("rst_res_zero", {31'd0, res_zero}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = i[1:0]; #1;
      chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]   op;
    logic [1:0]   rs1, rs2, rd;
    logic         imm_en;
    logic [W-1:0] imm;
    logic [W-1:0] y;
    logic         cout;
    logic         zero;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int p0;
    vecs[0] = '{3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0000, 16'h7A78, 1'b0, 1'b0};
    vecs[1] = '{3'b010, 2'd2, 2'd2, 2'd2, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{3'b011, 2'd0, 2'd3, 2'd1, 1'b1, 16'h00FF, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{3'b111, 2'd1, 2'd0, 2'd0, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0};
    vecs[4] = '{3'b101, 2'd1, 2'd1, 2'd1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{3'b110, 2'd3, 2'd0, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state, then a command on the first edge after release.
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b010, 2'd0, 2'd0, 2'd1, 1'b1, 16'h1234, 16'h5A5A, 1'b0, 1'b0);
    finish_cmd(2'd1, 16'h5A5A);

    // Add path.
    load(2'd1, 16'h8F54);
    load(2'd2, 16'h79F8);
    issue(3'b000, 2'd1, 2'd2, 2'd3, 1'b0, 16'h0000, 16'h094C, 1'b1, 1'b0);
    finish_cmd(2'd3, 16'h094C);

    // Immediate operand with a zero result.
    load(2'd1, 16'h93D2);
    issue(3'b100, 2'd1, 2'd0, 2'd0, 1'b1, 16'hED97, 16'h0000, 1'b0, 1'b1);
    finish_cmd(2'd0, 16'h0000);

    // Table of varied operand patterns, including rs1 == rs2 == rd.
    for (int i = 0; i < 6; i++) begin
      alu_y = 16'h0000;
      issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm_en,
            vecs[i].imm, vecs[i].y, vecs[i].cout, vecs[i].zero);
      finish_cmd(vecs[i].rd, vecs[i].y);
    end

    // A load to rs1 on the accept edge is not forwarded into alu_a.
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 16'hAAAA;
    issue(3'b000, 2'd1, 2'd3, 2'd2, 1'b0, 16'h0000, 16'h0F0F, 1'b0, 1'b0);
    model[1] = 16'hAAAA;
    finish_cmd(2'd2, 16'h0F0F);
    rd_addr = 2'd1; #1;
    chk("no_forward_load_landed", {16'd0, rd_data}, 32'h0000AAAA);

    // Back-to-back: cmd_valid held across two commands.
    @(negedge clk);
    p0 = pulses;
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2; cmd_rd = 2'd0;
    cmd_imm_en = 1'b0; alu_y = 16'h1111; alu_cout = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 16'h1111});
    @(posedge clk); @(negedge clk);
    model[0] = 16'h1111;
    cmd_op = 3'b011; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_rd = 2'd3;
    exp_q.push_back({1'b1, 1'b0, 16'h2222});
    chk("b2b_cmd_ready_exec", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("b2b_cmd_ready_wb", {31'd0, cmd_ready}, 32'd0);
    alu_y = 16'h2222; alu_cout = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("b2b_alu_op_held", {29'd0, alu_op}, 32'd1);
    chk("b2b_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_alu_a_second", {16'd0, alu_a}, 32'h00001111);
    chk("b2b_alu_op_second", {29'd0, alu_op}, 32'd3);
    @(posedge clk); @(negedge clk); #1;
    chk("b2b_pulse_gap", pulse_gap, 32'd30);
    @(posedge clk); @(negedge clk);
    model[3] = 16'h2222;
    chk("b2b_pulse_count", pulses - p0, 32'd2);

    // Collision: load to rd on the EXEC->WB edge loses to the writeback.
    issue(3'b000, 2'd0, 2'd3, 2'd2, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 16'hFFFF;
    finish_cmd(2'd2, 16'h1234);

    // Abort: reset asserted during EXEC.
    p0 = pulses;
    issue(3'b000, 2'd1, 2'd2, 2'd1, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
    rst_n = 1'b0; #1;
    void'(exp_q.pop_back());
    for (int i = 0; i < 4; i++) model[i] = '0;
    chk_reset_outputs();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_res_valid", pulses - p0, 32'd0);
    rd_addr = 2'd1; #1;
    chk("abort_rd_zero", {16'd0, rd_data}, 32'd0);
    chk("abort_state_idle", {30'd0, dbg_state}, 32'd0);

    // Randomised commands against the register model.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ry;
      logic [1:0]   rrd;
      @(negedge clk);
      load($urandom_range(0, 3), W'($urandom_range(0, 65535)));
      ry  = W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 65535));
      rrd = 2'($urandom_range(0, 3));
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            rrd, 1'($urandom_range(0, 1)), W'($urandom_range(0, 65535)),
            ry, 1'($urandom_range(0, 1)), ry == '0);
      finish_cmd(rrd, ry);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
